shift5_deser: RTL and testbench

SHIFT5_DESER -- requirements
Module: shift5_deser

---
 rtl/shift5_pkg.sv | 26 ++
 rtl/shift5_deser_if.sv | 32 +++
 rtl/shift5_deser_dff_sc.sv | 18 +
 rtl/shift5_deser.sv | 104 ++++++++++
 tb/tb_shift5_deser.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift5_pkg.sv
// Shared state encoding and sizing constants for shift5_deser.
// Frame length follows SHIFT5_DESER_PARITY_EN (6 bits with trailing even parity, else 5).
package shift5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned WORD_BITS = 5;

`ifdef SHIFT5_DESER_PARITY_EN
  localparam int unsigned FRAME_BITS = 6;
`else
  localparam int unsigned FRAME_BITS = 5;
`endif

  // Width of a counter that must hold max_val without overflow.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned BCNT_W = cnt_width(FRAME_BITS);

endpackage

// File: rtl/shift5_deser_if.sv
// Serial input / parallel word bus of shift5_deser.
// parity_err exists only when SHIFT5_DESER_PARITY_EN is defined.
interface shift5_deser_if;

  logic sin;
  logic sin_en;
  logic start;
  logic a, b, c, d, e;
  logic word_valid;
  logic busy;
  logic abort;
`ifdef SHIFT5_DESER_PARITY_EN
  logic parity_err;
`endif

  modport master (
    output sin, sin_en, start,
`ifdef SHIFT5_DESER_PARITY_EN
    input  parity_err,
`endif
    input  a, b, c, d, e, word_valid, busy, abort
  );

  modport slave (
    input  sin, sin_en, start,
`ifdef SHIFT5_DESER_PARITY_EN
    output parity_err,
`endif
    output a, b, c, d, e, word_valid, busy, abort
  );

endinterface

// File: rtl/shift5_deser_dff_sc.sv
// D flip-flop with synchronous clear and load enable.
module dff_sc (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift5_deser.sv
// Serial-to-parallel deserialiser: 5-bit word, MSB first, with an idle timeout inside a frame.
// Defining SHIFT5_DESER_PARITY_EN adds a trailing even-parity bit and the parity_err output.
module shift5_deser
  import shift5_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clear,
  shift5_deser_if.slave bus
);

  localparam int unsigned        TCNT_W   = cnt_width(TIMEOUT);
  localparam logic [BCNT_W-1:0]  LAST_BIT = BCNT_W'(FRAME_BITS);
  localparam logic [TCNT_W-1:0]  TLIMIT   = TCNT_W'(TIMEOUT);

  state_t               state, state_nxt;
  logic [WORD_BITS-1:0] sreg_q, sreg_d, shifted;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic                 load;
  logic                 abort_d, abort_q;

  // Shift left by one, dropping the oldest bit.
  assign shifted = WORD_BITS'({sreg_q, bus.sin});

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      state  <= state_nxt;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_d    = sreg_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    load      = 1'b0;
    abort_d   = 1'b0;
    if (state == DONE) begin
      state_nxt = IDLE;
    end else if (bus.start) begin
      // New frame or restart; a same-cycle strobe supplies the first bit.
      state_nxt = SHIFT;
      sreg_d    = bus.sin_en ? WORD_BITS'(bus.sin) : '0;
      bcnt_d    = BCNT_W'(bus.sin_en);
      tcnt_d    = '0;
    end else if (state == SHIFT) begin
      if (bus.sin_en) begin
        sreg_d = shifted;
        bcnt_d = bcnt_q + BCNT_W'(1);
        tcnt_d = '0;
        if (bcnt_d == LAST_BIT) begin
          state_nxt = DONE;
          load      = 1'b1;
        end
      end else begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (tcnt_d == TLIMIT) begin
          state_nxt = IDLE;
          abort_d   = 1'b1;
        end
      end
    end
  end

  // Word register loads on the last-bit edge so it is already valid during DONE.
`ifdef SHIFT5_DESER_PARITY_EN
  logic par_d, par_q;

  assign word_d = sreg_q;
  assign par_d  = ^{sreg_q, bus.sin};

  dff_sc u_par (.clk(clk), .clr(clear), .en(load), .d(par_d), .q(par_q));

  assign bus.parity_err = par_q & (state == DONE);
`else
  assign word_d = shifted;
`endif

  for (genvar i = 0; i < WORD_BITS; i++) begin : g_bits
    dff_sc u_sreg (.clk(clk), .clr(clear), .en(1'b1), .d(sreg_d[i]), .q(sreg_q[i]));
    dff_sc u_word (.clk(clk), .clr(clear), .en(load), .d(word_d[i]), .q(word_q[i]));
  end

  dff_sc u_abort (.clk(clk), .clr(clear), .en(1'b1), .d(abort_d), .q(abort_q));

  assign bus.a          = word_q[4];
  assign bus.b          = word_q[3];
  assign bus.c          = word_q[2];
  assign bus.d          = word_q[1];
  assign bus.e          = word_q[0];
  assign bus.word_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.abort      = abort_q;

endmodule

// File: tb/tb_shift5_deser.sv
// Bench for shift5_deser: directed frames then random traffic against a queue-based model.
module tb_shift5_deser;

  localparam int unsigned TIMEOUT = 15;
`ifdef SHIFT5_DESER_PARITY_EN
  localparam int unsigned FRAME_BITS = 6;
`else
  localparam int unsigned FRAME_BITS = 5;
`endif

  logic clk = 1'b0;
  logic clear;
  int   compared   = 0;
  int   mismatched = 0;

  shift5_deser_if bus_if ();

  shift5_deser #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Model: a frame is the queue of bits collected since the last start.
  bit         mq[$];
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_abort  = 1'b0;
  bit         m_par    = 1'b0;
  logic [4:0] m_word   = '0;
  int         m_idle   = 0;

  task automatic model_step(input logic clr, input logic st, input logic en, input logic s);
    m_abort = 1'b0;
    if (clr) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      mq.delete();
      m_word   = '0;
      m_par    = 1'b0;
      m_idle   = 0;
    end else if (m_done) begin
      m_done   = 1'b0;
      m_active = 1'b0;
    end else if (st) begin
      m_active = 1'b1;
      mq.delete();
      m_idle = 0;
      if (en) mq.push_back(s);
    end else if (m_active) begin
      if (en) begin
        mq.push_back(s);
        m_idle = 0;
        if (mq.size() == FRAME_BITS) begin
          for (int i = 0; i < 5; i++) m_word[4-i] = mq[i];
          m_par = 1'b0;
          foreach (mq[i]) m_par ^= mq[i];
          m_done = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_active = 1'b0;
          m_abort  = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_word();
    return {bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.e};
  endfunction

  task automatic check_all();
    check("word",       8'(dut_word()),      8'(m_word));
    check("word_valid", 8'(bus_if.word_valid), 8'(m_done));
    check("busy",       8'(bus_if.busy),     8'(m_active));
    check("abort",      8'(bus_if.abort),    8'(m_abort));
`ifdef SHIFT5_DESER_PARITY_EN
    check("parity_err", 8'(bus_if.parity_err), 8'(m_done & m_par));
`endif
  endtask

  task automatic cycle(input logic clr, input logic st, input logic en, input logic s);
    clear         = clr;
    bus_if.start  = st;
    bus_if.sin_en = en;
    bus_if.sin    = s;
    @(posedge clk);
    model_step(clr, st, en, s);
    #1;
    check_all();
  endtask

  task automatic send_bit(input logic s);
    cycle(1'b0, 1'b0, 1'b1, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [4:0] w);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(w[i]);
`ifdef SHIFT5_DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still-running expected finished");
    $fatal(1);
  end

  initial begin
    int en_pct;
    logic r_clr, r_st, r_en, r_s;

    clear         = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.sin_en = 1'b0;
    bus_if.sin    = 1'b0;

    // Two reset cycles, then a plain frame.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_word", 8'(dut_word()), 8'h00);
    check("rst_busy", 8'(bus_if.busy), 8'h0);
    send_frame(5'b10110);
    check("f1_word",  8'(dut_word()), 8'h16);
    check("f1_valid", 8'(bus_if.word_valid), 8'h1);
    idle(1);
    check("f1_valid_drop", 8'(bus_if.word_valid), 8'h0);

    // Timeout after three bits keeps the previous word.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    idle(TIMEOUT - 1);
    check("to_early_abort", 8'(bus_if.abort), 8'h0);
    idle(1);
    check("to_abort", 8'(bus_if.abort), 8'h1);
    check("to_busy",  8'(bus_if.busy),  8'h0);
    check("to_word",  8'(dut_word()),   8'h16);
    idle(1);
    check("to_abort_drop", 8'(bus_if.abort), 8'h0);

    // Restart mid-frame discards partial bits.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1);
    send_frame(5'b00101);
    check("rs_word", 8'(dut_word()), 8'h05);
    idle(1);

    // Clear mid-frame, then a full frame.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_word", 8'(dut_word()), 8'h00);
    check("clr_busy", 8'(bus_if.busy), 8'h0);
    send_frame(5'b11111);
    check("ones_word", 8'(dut_word()), 8'h1f);
    idle(1);

    // clear dominates start and sin_en.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_dom_busy", 8'(bus_if.busy), 8'h0);

    // Start with a same-cycle strobe; then start/strobe during the valid cycle are ignored.
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
`ifdef SHIFT5_DESER_PARITY_EN
    send_bit(1'b1);
`endif
    check("first_word", 8'(dut_word()), 8'h10);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("done_ign_busy", 8'(bus_if.busy), 8'h0);

    // One cycle short of the timeout, a strobe keeps the frame alive.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b0);
    idle(TIMEOUT - 1);
    check("edge_busy", 8'(bus_if.busy), 8'h1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
`ifdef SHIFT5_DESER_PARITY_EN
    send_bit(1'b1);
`endif
    check("edge_word", 8'(dut_word()), 8'h16);
    idle(1);

`ifdef SHIFT5_DESER_PARITY_EN
    // parity_err is the XOR of all six received bits.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1);
    check("par1_err",  8'(bus_if.parity_err), 8'h0);
    check("par1_word", 8'(dut_word()), 8'h16);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0);
    check("par0_err",   8'(bus_if.parity_err), 8'h1);
    check("par0_valid", 8'(bus_if.word_valid), 8'h1);
    check("par0_word",  8'(dut_word()), 8'h16);
    idle(1);
`endif

    // Random traffic, alternating dense and sparse strobe phases.
    en_pct = 75;
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) en_pct = ($urandom_range(0, 1) == 1) ? 75 : 4;
      r_clr = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < (m_active ? 3 : 15));
      r_en  = ($urandom_range(0, 99) < en_pct);
      r_s   = 1'($urandom_range(0, 1));
      cycle(r_clr, r_st, r_en, r_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
